// File: rtl/sram_line_pkg.sv
// -----------------------------------------------------------------------------
// sram_line_pkg
//   Shared types and constants for the SRAM line responder: FSM state encoding,
//   line geometry (beats, word width, byte-enable width) and small helper
//   functions used to walk the active beats of a line request.
// -----------------------------------------------------------------------------
package sram_line_pkg;

   localparam int unsigned BEATS  = 16;              // words per line
   localparam int unsigned WORD_W = 48;              // bits per SRAM word
   localparam int unsigned BE_W   = WORD_W / 8;      // byte enables per word
   localparam int unsigned BEAT_W = $clog2(BEATS);   // beat index width
   localparam int unsigned LINE_W = BEATS * WORD_W;  // full line data width
   localparam int unsigned MASK_W = BEATS * BE_W;    // full line byte-enable width

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StCapture,
      StDone
   } state_e;

   typedef struct packed {
      logic              valid;
      logic [BEAT_W-1:0] idx;
   } beat_sel_t;

   // Lowest set bit of a beat mask (priority encoder).
   function automatic beat_sel_t first_beat(input logic [BEATS-1:0] mask);
      beat_sel_t sel;
      sel = '0;
      for (int i = BEATS - 1; i >= 0; i--) begin
         if (mask[i]) begin
            sel.valid = 1'b1;
            sel.idx   = BEAT_W'(i);
         end
      end
      return sel;
   endfunction

   // Mask of all beats strictly above the given beat.
   function automatic logic [BEATS-1:0] beats_above(input logic [BEAT_W-1:0] beat);
      logic [BEATS-1:0] mask;
      for (int i = 0; i < BEATS; i++) begin
         mask[i] = (i > int'(beat));
      end
      return mask;
   endfunction

   // Beats that need an SRAM access: every beat for a read, only beats with a
   // nonzero byte-enable slice for a write.
   function automatic logic [BEATS-1:0] active_beats(input logic [MASK_W-1:0] dm,
                                                     input logic              we);
      logic [BEATS-1:0] mask;
      for (int i = 0; i < BEATS; i++) begin
         mask[i] = !we || (|dm[i*BE_W +: BE_W]);
      end
      return mask;
   endfunction

endpackage

// File: rtl/sram_line_responder.sv
// -----------------------------------------------------------------------------
// sram_line_responder
//   Line slave between the L2 cache SRAM master port and a word-wide SRAM
//   controller. A 16-word line request is serialised into single-word SRAM
//   accesses; reads are assembled back into a line and returned with ws_ack_o.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   ws_addr_i             line request byte address (line base = addr[31:6])
//   ws_din_i, ws_dm_i     write line data / byte enables, word k at slice k
//   ws_stb_i, ws_we_i     request strobe (level), 1 = write
//   ws_ack_o, ws_err_o    one-cycle completion pulse, abort flag with ack
//   ws_dout_o             last successfully read line
//   sram_addr_o           word byte address {line, beat, 2'b00}
//   sram_din_o, sram_dm_o write word / byte enables (dm = 0 means read)
//   sram_stb_o            word request
//   sram_nak_i            controller busy, request not taken this cycle
//   sram_dout_i           read word, valid the cycle after acceptance
// -----------------------------------------------------------------------------
module sram_line_responder
   import sram_line_pkg::*;
#(
   parameter int unsigned NAK_LIMIT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       ws_addr_i,
   input  logic [LINE_W-1:0] ws_din_i,
   input  logic [MASK_W-1:0] ws_dm_i,
   input  logic              ws_stb_i,
   input  logic              ws_we_i,
   output logic              ws_ack_o,
   output logic              ws_err_o,
   output logic [LINE_W-1:0] ws_dout_o,
   output logic [31:0]       sram_addr_o,
   output logic [WORD_W-1:0] sram_din_o,
   output logic [BE_W-1:0]   sram_dm_o,
   output logic              sram_stb_o,
   input  logic              sram_nak_i,
   input  logic [WORD_W-1:0] sram_dout_i
);

   localparam int unsigned NakW = $clog2(NAK_LIMIT + 1);

   // Request latched at acceptance; later input changes are ignored.
   state_e            state_q;
   logic [25:0]       base_q;
   logic [LINE_W-1:0] din_q;
   logic [MASK_W-1:0] dm_q;
   logic              we_q;
   logic [BEATS-1:0]  mask_q;
   logic [BEAT_W-1:0] beat_q;
   logic [NakW-1:0]   nak_cnt_q;
   logic [LINE_W-1:0] line_q;

   // Registered outputs.
   logic              ws_ack_q;
   logic              ws_err_q;
   logic [LINE_W-1:0] ws_dout_q;
   logic [31:0]       sram_addr_q;
   logic [WORD_W-1:0] sram_din_q;
   logic [BE_W-1:0]   sram_dm_q;
   logic              sram_stb_q;

   // Next-beat selection and the word that beat would drive.
   logic              src_idle;
   logic              src_we;
   logic [25:0]       src_base;
   logic [LINE_W-1:0] src_din;
   logic [MASK_W-1:0] src_dm;
   logic [BEATS-1:0]  cand_mask;
   beat_sel_t         nxt;
   logic [31:0]       issue_addr;
   logic [WORD_W-1:0] issue_din;
   logic [BE_W-1:0]   issue_dm;
   logic [LINE_W-1:0] line_capt;
   logic              nak_abort;

   // Byte offset bits within the line are not used by the line slave.
   logic unused_addr_bits;
   assign unused_addr_bits = ^ws_addr_i[5:0];

   always_comb begin
      // In IDLE the next beat comes straight from the request inputs so the
      // first SRAM word can be issued on the acceptance edge.
      src_idle = (state_q == StIdle);
      src_we   = src_idle ? ws_we_i : we_q;
      src_base = src_idle ? ws_addr_i[31:6] : base_q;
      src_din  = src_idle ? ws_din_i : din_q;
      src_dm   = src_idle ? ws_dm_i : dm_q;

      // Remaining active beats above the current one; for reads every beat is
      // active, so this yields beat+1. Zero-mask write beats drop out here.
      cand_mask = src_idle ? active_beats(ws_dm_i, ws_we_i)
                           : (mask_q & beats_above(beat_q));
      nxt = first_beat(cand_mask);

      issue_addr = {src_base, nxt.idx, 2'b00};
      issue_din  = src_we ? src_din[nxt.idx*WORD_W +: WORD_W] : '0;
      issue_dm   = src_we ? src_dm[nxt.idx*BE_W +: BE_W] : '0;

      line_capt = line_q;
      line_capt[beat_q*WORD_W +: WORD_W] = sram_dout_i;

      nak_abort = sram_nak_i && (nak_cnt_q == NakW'(NAK_LIMIT - 1));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         base_q      <= '0;
         din_q       <= '0;
         dm_q        <= '0;
         we_q        <= 1'b0;
         mask_q      <= '0;
         beat_q      <= '0;
         nak_cnt_q   <= '0;
         line_q      <= '0;
         ws_ack_q    <= 1'b0;
         ws_err_q    <= 1'b0;
         ws_dout_q   <= '0;
         sram_addr_q <= '0;
         sram_din_q  <= '0;
         sram_dm_q   <= '0;
         sram_stb_q  <= 1'b0;
      end else begin
         ws_ack_q <= 1'b0;
         ws_err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (ws_stb_i) begin
                  base_q    <= ws_addr_i[31:6];
                  din_q     <= ws_din_i;
                  dm_q      <= ws_dm_i;
                  we_q      <= ws_we_i;
                  mask_q    <= cand_mask;
                  nak_cnt_q <= '0;
                  if (nxt.valid) begin
                     beat_q      <= nxt.idx;
                     sram_stb_q  <= 1'b1;
                     sram_addr_q <= issue_addr;
                     sram_din_q  <= issue_din;
                     sram_dm_q   <= issue_dm;
                     state_q     <= StIssue;
                  end else begin
                     // Write with an all-zero mask: nothing to send.
                     ws_ack_q <= 1'b1;
                     state_q  <= StDone;
                  end
               end
            end

            StIssue: begin
               if (sram_nak_i) begin
                  if (nak_abort) begin
                     sram_stb_q <= 1'b0;
                     ws_ack_q   <= 1'b1;
                     ws_err_q   <= 1'b1;
                     state_q    <= StDone;
                  end else begin
                     nak_cnt_q <= nak_cnt_q + 1'b1;
                  end
               end else begin
                  nak_cnt_q <= '0;
                  if (!we_q) begin
                     sram_stb_q <= 1'b0;
                     state_q    <= StCapture;
                  end else if (nxt.valid) begin
                     // Back-to-back write beats: strobe stays high.
                     beat_q      <= nxt.idx;
                     sram_addr_q <= issue_addr;
                     sram_din_q  <= issue_din;
                     sram_dm_q   <= issue_dm;
                  end else begin
                     sram_stb_q <= 1'b0;
                     ws_ack_q   <= 1'b1;
                     state_q    <= StDone;
                  end
               end
            end

            StCapture: begin
               line_q <= line_capt;
               if (beat_q == BEAT_W'(BEATS - 1)) begin
                  // Publish the line together with ack, including the final word.
                  ws_dout_q <= line_capt;
                  ws_ack_q  <= 1'b1;
                  state_q   <= StDone;
               end else begin
                  beat_q      <= nxt.idx;
                  sram_stb_q  <= 1'b1;
                  sram_addr_q <= issue_addr;
                  sram_din_q  <= issue_din;
                  sram_dm_q   <= issue_dm;
                  state_q     <= StIssue;
               end
            end

            StDone: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign ws_ack_o    = ws_ack_q;
   assign ws_err_o    = ws_err_q;
   assign ws_dout_o   = ws_dout_q;
   assign sram_addr_o = sram_addr_q;
   assign sram_din_o  = sram_din_q;
   assign sram_dm_o   = sram_dm_q;
   assign sram_stb_o  = sram_stb_q;

endmodule

// File: tb/tb_sram_line_responder.sv
module tb_sram_line_responder;
   import sram_line_pkg::*;

   localparam int KIssue = 0;
   localparam int KGap   = 1;
   localparam int KAck   = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       ws_addr;
   logic [LINE_W-1:0] ws_din;
   logic [MASK_W-1:0] ws_dm;
   logic              ws_stb;
   logic              ws_we;
   logic              ws_ack;
   logic              ws_err;
   logic [LINE_W-1:0] ws_dout;
   logic [31:0]       sram_addr;
   logic [WORD_W-1:0] sram_din;
   logic [BE_W-1:0]   sram_dm;
   logic              sram_stb;
   logic              sram_nak;
   logic [WORD_W-1:0] sram_dout;

   sram_line_responder #(.NAK_LIMIT(255)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .ws_addr_i   (ws_addr),
      .ws_din_i    (ws_din),
      .ws_dm_i     (ws_dm),
      .ws_stb_i    (ws_stb),
      .ws_we_i     (ws_we),
      .ws_ack_o    (ws_ack),
      .ws_err_o    (ws_err),
      .ws_dout_o   (ws_dout),
      .sram_addr_o (sram_addr),
      .sram_din_o  (sram_din),
      .sram_dm_o   (sram_dm),
      .sram_stb_o  (sram_stb),
      .sram_nak_i  (sram_nak),
      .sram_dout_i (sram_dout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   function automatic void chk(string name, logic [LINE_W-1:0] got, logic [LINE_W-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endfunction

   // Memory contents seen by the SRAM controller stand-in.
   function automatic logic [47:0] mem_word(logic [31:0] a);
      return 48'h0A0B_0000_0000 + 48'(a[5:2]) + ((48'(a[31:6]) ^ 48'hFFFF) << 16);
   endfunction

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   // Random byte enables with roughly a third of the words fully masked off.
   function automatic logic [MASK_W-1:0] rand_mask();
      logic [MASK_W-1:0] m;
      for (int i = 0; i < BEATS; i++) m[i*BE_W +: BE_W] = ($urandom % 3 == 0) ? '0 : BE_W'($urandom);
      return m;
   endfunction

   // Reference model: the expected remaining sequence of cycles of a request.
   typedef struct {
      int          kind;
      int          beat;
      logic [31:0] addr;
      logic [47:0] din;
      logic [5:0]  dm;
   } ph_t;

   ph_t               q[$];
   logic              exp_err;
   logic [LINE_W-1:0] exp_dout;
   logic [LINE_W-1:0] pending;
   logic              cur_we;
   int                nak_run, lat, last_lat, ack_cnt = 0, err_cnt = 0;
   int                nak_mode = 0, nak_beat = 0, nak_len = 0;
   int                issue_seen;
   logic [31:0]       obs_first_addr, obs_last_addr;
   logic [47:0]       obs_din;
   logic [5:0]        obs_dm;

   function automatic void build();
      ph_t p;
      q.delete();
      exp_err = 1'b0;
      cur_we = ws_we;
      lat = 0;
      nak_run = 0;
      issue_seen = 0;
      for (int k = 0; k < BEATS; k++) begin
         p.beat = k;
         p.addr = {ws_addr[31:6], 4'(k), 2'b00};
         if (!ws_we) begin
            p.kind = KIssue; p.din = '0; p.dm = '0;
            q.push_back(p);
            p.kind = KGap;
            q.push_back(p);
            pending[k*WORD_W +: WORD_W] = mem_word(p.addr);
         end else if (ws_dm[k*BE_W +: BE_W] != '0) begin
            p.kind = KIssue;
            p.din = ws_din[k*WORD_W +: WORD_W];
            p.dm = ws_dm[k*BE_W +: BE_W];
            q.push_back(p);
         end
      end
      p.kind = KAck; p.beat = 0; p.addr = '0; p.din = '0; p.dm = '0;
      q.push_back(p);
   endfunction

   // Compare process: checks every cycle, then drives the SRAM side.
   initial begin
      ph_t p;
      bit  busy, nak;
      sram_nak = 1'b0;
      sram_dout = '0;
      exp_dout = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            q.delete();
            exp_dout = '0;
            exp_err = 1'b0;
            sram_nak = 1'b0;
            continue;
         end
         busy = (q.size() > 0);
         if (!busy) begin
            chk("idle_stb", LINE_W'(sram_stb), LINE_W'(1'b0));
            chk("idle_ack", LINE_W'(ws_ack), LINE_W'(1'b0));
         end else begin
            p = q[0];
            lat++;
            if (p.kind == KIssue) begin
               chk("stb", LINE_W'(sram_stb), LINE_W'(1'b1));
               chk("addr", LINE_W'(sram_addr), LINE_W'(p.addr));
               chk("din", LINE_W'(sram_din), LINE_W'(p.din));
               chk("dm", LINE_W'(sram_dm), LINE_W'(p.dm));
               chk("ack_early", LINE_W'(ws_ack), LINE_W'(1'b0));
               if (issue_seen == 0) begin
                  obs_first_addr = sram_addr;
                  obs_din = sram_din;
                  obs_dm = sram_dm;
               end
               obs_last_addr = sram_addr;
               issue_seen++;
            end else if (p.kind == KGap) begin
               chk("gap_stb", LINE_W'(sram_stb), LINE_W'(1'b0));
               chk("ack_early", LINE_W'(ws_ack), LINE_W'(1'b0));
            end else begin
               chk("ack", LINE_W'(ws_ack), LINE_W'(1'b1));
               chk("err", LINE_W'(ws_err), LINE_W'(exp_err));
               chk("ack_stb", LINE_W'(sram_stb), LINE_W'(1'b0));
               last_lat = lat;
               ack_cnt++;
               if (exp_err) err_cnt++;
            end
         end
         if (!(busy && q[0].kind == KAck)) chk("err_idle", LINE_W'(ws_err), LINE_W'(1'b0));
         chk("dout", ws_dout, exp_dout);

         nak = 1'b0;
         sram_dout = 48'({$urandom, $urandom});
         if (busy && p.kind == KIssue) begin
            if (nak_mode == 1) nak = ($urandom % 4 == 0);
            else if (nak_mode == 2) nak = (p.beat == nak_beat) && (nak_run < nak_len);
         end
         if (busy && p.kind == KGap) sram_dout = mem_word(p.addr);
         sram_nak = nak;

         if (busy) begin
            if (p.kind == KIssue && nak) begin
               nak_run++;
               if (nak_run == 255) begin
                  q.delete();
                  p.kind = KAck;
                  q.push_back(p);
                  exp_err = 1'b1;
               end
            end else begin
               nak_run = 0;
               void'(q.pop_front());
               if (q.size() > 0 && q[0].kind == KAck && !cur_we && !exp_err) exp_dout = pending;
            end
         end else if (ws_stb) begin
            build();
         end
      end
   end

   task automatic scramble();
      ws_addr = $urandom;
      ws_we = 1'($urandom);
      ws_stb = 1'($urandom);
      ws_dm = rand_mask();
      ws_din = rand_line();
   endtask

   task automatic start_req(logic we, logic [31:0] addr, logic [LINE_W-1:0] din,
                            logic [MASK_W-1:0] dm);
      @(posedge clk);
      #2;
      ws_we = we;
      ws_addr = addr;
      ws_din = din;
      ws_dm = dm;
      ws_stb = 1'b1;
   endtask

   task automatic wait_ack(bit scr);
      int start;
      bit ok;
      start = ack_cnt;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #2;
         if (ack_cnt != start) begin
            ok = 1'b1;
            break;
         end
         if (scr) scramble();
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout got no ack want ack within 2000 cycles");
      end
   endtask

   task automatic do_req(logic we, logic [31:0] addr, logic [LINE_W-1:0] din,
                         logic [MASK_W-1:0] dm, bit scr);
      start_req(we, addr, din, dm);
      wait_ack(scr);
      ws_stb = 1'b0;
   endtask

   initial begin
      logic [LINE_W-1:0] din;
      int e0, a0;
      rst = 1'b1;
      ws_addr = '0; ws_din = '0; ws_dm = '0; ws_stb = 1'b0; ws_we = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_stb", LINE_W'(sram_stb), LINE_W'(1'b0));
      chk("rst_ack", LINE_W'(ws_ack), LINE_W'(1'b0));
      chk("rst_dout", ws_dout, '0);
      @(posedge clk);
      #2 rst = 1'b0;

      // Full line read at the top of a 4 MB window.
      do_req(1'b0, 32'h003FFFC0, '0, '0, 1'b1);
      chk("rd_latency", LINE_W'(last_lat), LINE_W'(33));
      chk("rd_word0", LINE_W'(ws_dout[47:0]), LINE_W'(48'h0A0B_0000_0000));
      chk("rd_word15", LINE_W'(ws_dout[15*48 +: 48]), LINE_W'(48'h0A0B_0000_000F));
      chk("rd_first_addr", LINE_W'(obs_first_addr), LINE_W'(32'h003FFFC0));
      chk("rd_last_addr", LINE_W'(obs_last_addr), LINE_W'(32'h003FFFFC));

      // Single-word write.
      din = rand_line();
      din[47:0] = 48'h0FFC_DEADBEEF;
      do_req(1'b1, 32'h003FFFC0, din, 96'h3F, 1'b1);
      chk("wr1_latency", LINE_W'(last_lat), LINE_W'(2));
      chk("wr1_addr", LINE_W'(obs_first_addr), LINE_W'(32'h003FFFC0));
      chk("wr1_dm", LINE_W'(obs_dm), LINE_W'(6'h3F));
      chk("wr1_din", LINE_W'(obs_din), LINE_W'(48'h0FFC_DEADBEEF));
      chk("wr1_count", LINE_W'(issue_seen), LINE_W'(1));

      // Empty write.
      do_req(1'b1, 32'h00000040, rand_line(), '0, 1'b1);
      chk("wr0_latency", LINE_W'(last_lat), LINE_W'(1));
      chk("wr0_count", LINE_W'(issue_seen), LINE_W'(0));

      // Read with a 3-cycle nak on beat 5.
      nak_mode = 2; nak_beat = 5; nak_len = 3;
      do_req(1'b0, 32'h003FFFC0, '0, '0, 1'b1);
      chk("nak_latency", LINE_W'(last_lat), LINE_W'(36));
      chk("nak_word5", LINE_W'(ws_dout[5*48 +: 48]), LINE_W'(48'h0A0B_0000_0005));

      // Abort after 255 naks on beat 2; the line output must stay untouched.
      nak_beat = 2; nak_len = 1000;
      e0 = err_cnt;
      do_req(1'b0, 32'h12345680, '0, '0, 1'b1);
      chk("abort_err", LINE_W'(err_cnt - e0), LINE_W'(1));
      chk("abort_latency", LINE_W'(last_lat), LINE_W'(260));
      chk("abort_dout", LINE_W'(ws_dout[47:0]), LINE_W'(48'h0A0B_0000_0000));
      nak_mode = 0;

      // Asynchronous reset in the middle of beat 7.
      start_req(1'b0, 32'h00001000, '0, '0);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #3;
         if (q.size() > 0 && q[0].kind == KIssue && q[0].beat == 7) break;
      end
      rst = 1'b1;
      ws_stb = 1'b0;
      #1;
      chk("arst_stb", LINE_W'(sram_stb), LINE_W'(1'b0));
      chk("arst_addr", LINE_W'(sram_addr), '0);
      chk("arst_ack", LINE_W'(ws_ack), LINE_W'(1'b0));
      chk("arst_dout", ws_dout, '0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      do_req(1'b0, 32'h003FFFC0, '0, '0, 1'b0);
      chk("restart_addr", LINE_W'(obs_first_addr), LINE_W'(32'h003FFFC0));

      // ws_stb held high across ack: next request taken in the IDLE cycle.
      a0 = ack_cnt;
      start_req(1'b0, 32'h00ABC000, '0, '0);
      wait_ack(1'b0);
      ws_we = 1'b1;
      ws_addr = 32'h00ABC040;
      ws_dm = rand_mask();
      ws_din = rand_line();
      wait_ack(1'b0);
      ws_stb = 1'b0;
      chk("b2b_acks", LINE_W'(ack_cnt - a0), LINE_W'(2));

      // Randomized traffic with random naks and input churn while busy.
      nak_mode = 1;
      for (int n = 0; n < 40; n++) begin
         do_req(1'($urandom), $urandom, rand_line(), rand_mask(), 1'b1);
      end
      nak_mode = 0;
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
